mem_bus_arbiter: RTL and testbench

//  Shares the single external Z80-style memory/IO bus between the fetch port and the MEM-stage data port.

---
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Z80-style bus arbiter sharing one external bus between fetch and the MEM data port.
// The data port wins by default; a starvation counter forces fetch after STARVE_MAX losses.
module mem_bus_arbiter #(
    parameter int ACC_CYCLES = 3,
    parameter int IO_EXTRA   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_req,
    input  logic [15:0] I_addr,
    output logic [7:0]  I_data,
    output logic        I_wait,
    input  logic        D_mreq,
    input  logic        D_iorq,
    input  logic        D_rd,
    input  logic        D_wr,
    input  logic [15:0] D_addr,
    input  logic [7:0]  D_wdata,
    output logic [7:0]  D_rdata,
    output logic        D_wait,
    output logic [15:0] B_addr,
    output logic [7:0]  B_wdata,
    input  logic [7:0]  B_rdata,
    output logic        B_mreq,
    output logic        B_iorq,
    output logic        B_rd,
    output logic        B_wr,
    input  logic        B_wait
);
    localparam int CW = $clog2(ACC_CYCLES + IO_EXTRA + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic [15:0]   r_addr;
    logic [7:0]    r_wdata;
    logic          r_io;
    logic          r_rd;
    logic          r_wr;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_starve;
    logic [7:0]    r_idata;
    logic [7:0]    r_drdata;

    logic w_dreq;
    logic w_dio;
    logic w_gnt_d;
    logic w_gnt_i;
    logic w_grant;
    logic w_last;
    logic w_starved;

    assign w_dreq    = D_mreq | D_iorq;
    assign w_dio     = D_iorq & ~D_mreq;
    assign w_starved = (r_starve == SW'(STARVE_MAX));
    assign w_gnt_d   = w_dreq & ~(I_req & w_starved);
    assign w_gnt_i   = I_req & ~w_gnt_d;
    assign w_grant   = (r_state == S_IDLE) & (w_gnt_d | w_gnt_i);
    assign w_last    = (r_state == S_ACCESS) & ~B_wait
                     & (r_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_grant) w_next = S_ACCESS;
            S_ACCESS: if (w_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        B_addr  = '0;
        B_wdata = '0;
        B_mreq  = 1'b0;
        B_iorq  = 1'b0;
        B_rd    = 1'b0;
        B_wr    = 1'b0;
        if (r_state == S_ACCESS) begin
            B_addr  = r_addr;
            B_wdata = r_wdata;
            B_mreq  = ~r_io;
            B_iorq  = r_io;
            B_rd    = r_rd;
            B_wr    = r_wr;
        end
        I_wait = I_req & ~((r_state == S_DONE) & ~r_owner);
        D_wait = w_dreq & ~((r_state == S_DONE) & r_owner);
    end

    // Fetch is always a memory read; write wins when the data port asserts both.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_owner  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_io     <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_cnt    <= '0;
            r_starve <= '0;
            r_idata  <= '0;
            r_drdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_gnt_d;
                r_addr  <= w_gnt_d ? D_addr : I_addr;
                r_wdata <= w_gnt_d ? D_wdata : 8'h00;
                r_io    <= w_gnt_d & w_dio;
                r_wr    <= w_gnt_d & D_wr;
                r_rd    <= w_gnt_d ? (D_rd & ~D_wr) : 1'b1;
                r_cnt   <= CW'(ACC_CYCLES - 1)
                         + ((w_gnt_d & w_dio) ? CW'(IO_EXTRA) : CW'(0));
                if (!w_gnt_d)
                    r_starve <= '0;
                else if (I_req && !w_starved)
                    r_starve <= r_starve + SW'(1);
            end
            if ((r_state == S_ACCESS) && !B_wait && (r_cnt != '0))
                r_cnt <= r_cnt - CW'(1);
            if (w_last && r_rd) begin
                if (r_owner) r_drdata <= B_rdata;
                else         r_idata  <= B_rdata;
            end
        end
    end

    assign I_data  = r_idata;
    assign D_rdata = r_drdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed multi-cycle sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;
    localparam int ACC  = 3;
    localparam int IOX  = 1;
    localparam int SMAX = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_req;
    logic [15:0] I_addr;
    logic [7:0]  I_data;
    logic        I_wait;
    logic        D_mreq, D_iorq, D_rd, D_wr;
    logic [15:0] D_addr;
    logic [7:0]  D_wdata;
    logic [7:0]  D_rdata;
    logic        D_wait;
    logic [15:0] B_addr;
    logic [7:0]  B_wdata;
    logic [7:0]  B_rdata;
    logic        B_mreq, B_iorq, B_rd, B_wr;
    logic        B_wait;
    logic        use_fix;
    logic [7:0]  fix_data;
    logic        w_strobe;

    int npass = 0;
    int ntot  = 0;

    function automatic logic [7:0] bus_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h96;
    endfunction

    assign B_rdata  = use_fix ? fix_data : bus_val(B_addr);
    assign w_strobe = B_mreq | B_iorq | B_rd | B_wr;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(
        .ACC_CYCLES(ACC), .IO_EXTRA(IOX), .STARVE_MAX(SMAX)
    ) dut (
        .CLK(CLK), .RST(RST),
        .I_req(I_req), .I_addr(I_addr),
        .I_data(I_data), .I_wait(I_wait),
        .D_mreq(D_mreq), .D_iorq(D_iorq),
        .D_rd(D_rd), .D_wr(D_wr),
        .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_wait(D_wait),
        .B_addr(B_addr), .B_wdata(B_wdata),
        .B_rdata(B_rdata),
        .B_mreq(B_mreq), .B_iorq(B_iorq),
        .B_rd(B_rd), .B_wr(B_wr),
        .B_wait(B_wait)
    );

    typedef struct {
        logic        mreq, iorq, rd, wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  bus;
        int          cycles;
        logic [3:0]  bsig;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl[6];
    bit   exp_ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        I_req = 0; I_addr = '0;
        D_mreq = 0; D_iorq = 0; D_rd = 0; D_wr = 0;
        D_addr = '0; D_wdata = '0;
        B_wait = 0;
    endtask

    task automatic do_reset();
        RST = 1;
        clear_inputs();
        use_fix = 0; fix_data = '0;
        tick();
        tick();
        check("reset bus", {B_mreq, B_iorq, B_rd, B_wr, B_addr, B_wdata}, 0);
        check("reset data", {I_data, D_rdata}, 0);
        check("reset waits", {I_wait, D_wait}, 0);
        RST = 0;
    endtask

    // Count completions in order, checking owner and returned read data.
    task automatic collect(input int n, input string tag);
        int   got;
        logic own;
        got = 0;
        for (int c = 0; c < 300 && got < n; c++) begin
            tick();
            if ((D_mreq | D_iorq) && !D_wait) begin
                own = 1'b1;
                check($sformatf("%s data%0d", tag, got),
                      D_rdata, bus_val(D_addr));
            end else if (I_req && !I_wait) begin
                own = 1'b0;
                check($sformatf("%s fetch%0d", tag, got),
                      I_data, bus_val(I_addr));
            end else begin
                continue;
            end
            check($sformatf("%s order%0d", tag, got), own, exp_ord[got]);
            got++;
        end
        check($sformatf("%s count", tag), got, n);
    endtask

    // Random-phase model state
    int          starve, nstrobe, nwait, base, ncomp;
    logic        pred_d, prev_i, prev_d, prev_strobe, prev_done;
    logic        done_i, done_d, dio;
    logic [3:0]  esig;
    logic [15:0] eaddr;
    logic [7:0]  ewdata, exp_i, exp_d;
    int          n, nbad, lat, nd, ns;
    logic        done, fired;

    initial begin
        tbl[0] = '{1, 0, 1, 0, 16'hC000, 8'h00, 8'h5A, 3, 4'b1010, 8'h5A};
        tbl[1] = '{0, 1, 0, 1, 16'h00BE, 8'h3C, 8'h11, 4, 4'b0101, 8'h5A};
        tbl[2] = '{1, 1, 1, 1, 16'h1234, 8'h77, 8'h22, 3, 4'b1001, 8'h5A};
        tbl[3] = '{0, 1, 1, 0, 16'h0042, 8'h00, 8'hE1, 4, 4'b0110, 8'hE1};
        tbl[4] = '{1, 0, 1, 1, 16'hFFFF, 8'hA5, 8'h33, 3, 4'b1001, 8'hE1};
        tbl[5] = '{1, 0, 1, 0, 16'h0000, 8'h00, 8'h00, 3, 4'b1010, 8'h00};

        do_reset();

        for (int k = 0; k < 6; k++) begin
            use_fix = 1; fix_data = tbl[k].bus;
            D_mreq = tbl[k].mreq; D_iorq = tbl[k].iorq;
            D_rd = tbl[k].rd; D_wr = tbl[k].wr;
            D_addr = tbl[k].addr; D_wdata = tbl[k].wdata;
            n = 0; nbad = 0; lat = 0; done = 0;
            for (int c = 1; c <= 20 && !done; c++) begin
                tick();
                if (w_strobe) begin
                    n++;
                    if ({B_mreq, B_iorq, B_rd, B_wr} !== tbl[k].bsig ||
                        B_addr !== tbl[k].addr ||
                        (tbl[k].bsig[0] && B_wdata !== tbl[k].wdata))
                        nbad++;
                end
                if (!D_wait) begin done = 1; lat = c; end
            end
            check($sformatf("vec%0d strobes", k), n, tbl[k].cycles);
            check($sformatf("vec%0d bus", k), nbad, 0);
            check($sformatf("vec%0d latency", k), lat, tbl[k].cycles + 1);
            check($sformatf("vec%0d rdata", k), D_rdata, tbl[k].rdata);
            clear_inputs();
            tick();
        end

        // Fetch stretched by two external wait cycles
        use_fix = 1; fix_data = 8'h3E;
        I_req = 1; I_addr = 16'h8000;
        n = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (w_strobe) begin
                n++;
                if (n == 1)
                    check("wait fetch bus",
                          {B_mreq, B_iorq, B_rd, B_wr, B_addr},
                          {4'b1010, 16'h8000});
                if (n == 5) check("wait early capture", I_data, 8'h00);
            end
            B_wait = (n == 2 || n == 3) && w_strobe;
            if (!I_wait) done = 1;
        end
        check("wait strobes", n, 5);
        check("wait idata", I_data, 8'h3E);
        clear_inputs();
        use_fix = 0;
        tick();

        // Continuous contention: starvation forces every fifth grant to fetch
        I_req = 1; I_addr = 16'h4000;
        D_mreq = 1; D_rd = 1; D_addr = 16'h2000;
        collect(10, "starve");
        clear_inputs();
        tick();

        // Reset in the second ACCESS cycle of the second data access
        I_req = 1; I_addr = 16'h4000;
        D_mreq = 1; D_rd = 1; D_addr = 16'h3000;
        nd = 0; ns = 0; fired = 0;
        for (int c = 0; c < 40 && !fired; c++) begin
            tick();
            if (!D_wait) nd++;
            if (w_strobe) ns++;
            else ns = 0;
            if (nd == 1 && ns == 2) begin RST = 1; fired = 1; end
        end
        check("rst reached", fired, 1);
        tick();
        RST = 0;
        check("rst bus", {B_mreq, B_iorq, B_rd, B_wr, B_addr, B_wdata}, 0);
        check("rst waits", {I_wait, D_wait}, {I_req, D_mreq | D_iorq});
        check("rst data", {I_data, D_rdata}, 0);
        collect(5, "rst");
        clear_inputs();
        tick();

        // Random traffic against a transaction-level model
        do_reset();
        starve = 0; ncomp = 0; nstrobe = 0; nwait = 0; base = 0;
        pred_d = 0; prev_i = 0; prev_d = 0;
        prev_strobe = 0; prev_done = 0;
        exp_i = 0; exp_d = 0;
        esig = 0; eaddr = 0; ewdata = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (!prev_strobe && !prev_done && (prev_i || prev_d))
                check("rand grant", w_strobe, 1);
            if (w_strobe && !prev_strobe) begin
                pred_d = prev_d && !(prev_i && starve == SMAX);
                if (!pred_d) starve = 0;
                else if (prev_i && starve < SMAX) starve++;
                dio = D_iorq & ~D_mreq;
                esig = pred_d ? {~dio, dio, D_rd & ~D_wr, D_wr}
                              : 4'b1010;
                eaddr = pred_d ? D_addr : I_addr;
                ewdata = (pred_d && D_wr) ? D_wdata : 8'h00;
                base = ACC + ((pred_d && dio) ? IOX : 0);
                nstrobe = 0; nwait = 0;
            end
            if (w_strobe) begin
                nstrobe++;
                check("rand bus",
                      {B_mreq, B_iorq, B_rd, B_wr, B_addr,
                       (B_wr ? B_wdata : 8'h00)},
                      {esig, eaddr, ewdata});
            end
            done_i = I_req && !I_wait;
            done_d = (D_mreq | D_iorq) && !D_wait;
            if (done_i || done_d) begin
                ncomp++;
                check("rand owner", {done_i, done_d}, {~pred_d, pred_d});
                check("rand length", nstrobe, base + nwait);
                if (pred_d && esig[1]) exp_d = bus_val(eaddr);
                if (!pred_d) exp_i = bus_val(eaddr);
                check("rand idata", I_data, exp_i);
                check("rand drdata", D_rdata, exp_d);
            end
            if (done_i) I_req = 0;
            else if (!I_req && $urandom_range(0, 1) == 1) begin
                I_req = 1; I_addr = 16'($urandom);
            end
            if (done_d) begin
                D_mreq = 0; D_iorq = 0; D_rd = 0; D_wr = 0;
            end else if (!(D_mreq | D_iorq) && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0: begin D_mreq = 1; D_iorq = 0; end
                    1: begin D_mreq = 0; D_iorq = 1; end
                    default: begin D_mreq = 1; D_iorq = 1; end
                endcase
                case ($urandom_range(0, 2))
                    0: begin D_rd = 1; D_wr = 0; end
                    1: begin D_rd = 0; D_wr = 1; end
                    default: begin D_rd = 1; D_wr = 1; end
                endcase
                D_addr = 16'($urandom);
                D_wdata = 8'($urandom);
            end
            B_wait = ($urandom_range(0, 4) == 0);
            if (w_strobe && B_wait) nwait++;
            prev_i = I_req;
            prev_d = D_mreq | D_iorq;
            prev_strobe = w_strobe;
            prev_done = done_i | done_d;
        end
        check("rand progress", ncomp >= 50, 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
